// File: rtl/fp_result_queue.sv
`default_nettype none
// ============================================================================
// Module      : fp_result_queue
// Description : In-order result buffer behind fp_adder. Captures each result
//               pulse together with its flags and precision mode, provides
//               backpressure through in_ready, presents entries first-word-
//               fall-through on a valid/ready port, and keeps a software-
//               clearable sticky OR of all accepted exception flags.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_result_queue #(
    parameter int DEPTH  = 4,   // power of two, >= 2
    parameter int DATA_W = 32,
    parameter int FLAG_W = 5
) (
    input  logic                         clk,
    input  logic                         rst_n,
    // producer side (fp_adder)
    input  logic                         in_valid,
    input  logic [DATA_W-1:0]            in_result,
    input  logic [FLAG_W-1:0]            in_flags,
    input  logic                         in_mode_fp,
    output logic                         in_ready,
    // consumer side
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_W-1:0]            out_result,
    output logic [FLAG_W-1:0]            out_flags,
    output logic                         out_mode_fp,
    // status
    output logic [FLAG_W-1:0]            sticky_flags,
    input  logic                         sticky_clr,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         overflow_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int ENT_W = 1 + FLAG_W + DATA_W;   // {mode, flags, result}
    localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] C_ONE   = CNT_W'(1);
    localparam logic [PTR_W-1:0] C_PINC  = PTR_W'(1);

    logic [ENT_W-1:0]  r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [FLAG_W-1:0] r_sticky;
    logic              r_overflow;

    logic              w_push;
    logic              w_pop;
    logic [DATA_W-1:0] w_store_result;
    logic [ENT_W-1:0]  w_entry;
    logic [ENT_W-1:0]  w_head;

    // Handshake qualification; both sides depend only on registered count,
    // so there is no combinational path from in_valid to out_valid.
    assign in_ready  = (r_count != C_DEPTH);
    assign out_valid = (r_count != '0);
    assign w_push    = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;

    // Half-precision results only carry the low 16 bits; the upper half is
    // forced to zero so stale adder bits never reach the consumer.
    generate
        if (DATA_W > 16) begin : g_half_zero
            assign w_store_result = in_mode_fp ? in_result
                                               : {{(DATA_W-16){1'b0}}, in_result[15:0]};
        end else begin : g_half_pass
            assign w_store_result = in_result;
        end
    endgenerate

    assign w_entry = {in_mode_fp, in_flags, w_store_result};
    assign w_head  = r_mem[r_rd_ptr];

    // Head is presented directly from storage; outputs read zero when empty.
    assign out_result  = out_valid ? w_head[DATA_W-1:0]              : '0;
    assign out_flags   = out_valid ? w_head[DATA_W +: FLAG_W]        : '0;
    assign out_mode_fp = out_valid ? w_head[ENT_W-1]                 : 1'b0;

    assign count        = r_count;
    assign sticky_flags = r_sticky;
    assign overflow_err = r_overflow;

    // Storage, pointers and occupancy; pointers wrap naturally (DEPTH is 2^n).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_entry;
                r_wr_ptr        <= r_wr_ptr + C_PINC;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + C_PINC;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + C_ONE;
                2'b01:   r_count <= r_count - C_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky exception accumulator: a clear coinciding with a push keeps
    // only the new result's flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sticky <= '0;
        end else if (sticky_clr && w_push) begin
            r_sticky <= in_flags;
        end else if (sticky_clr) begin
            r_sticky <= '0;
        end else if (w_push) begin
            r_sticky <= r_sticky | in_flags;
        end
    end

    // Overflow: a result offered while full is dropped and latched until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
        end else if (in_valid && !in_ready) begin
            r_overflow <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: doc/fp_result_queue.md
Name: fp_result_queue

Overview:
- Result buffer directly downstream of fp_adder.
- Captures each completed operation (result, flags, precision mode) on fp_adder's valid_out pulse.
- Drives fp_adder's ready_in as backpressure and presents results in order on a valid/ready consumer port.
- Keeps a sticky accumulated-exception register, cleared by software, for the downstream register file/CSR logic.

Parameters:
- DEPTH, 4, number of entries; power of two, minimum 2.
- DATA_W, 32, result width; matches fp_adder result.
- FLAG_W, 5, exception flag width; matches fp_adder flags.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  connected to fp_adder valid_out; one-cycle pulse per result.
- in_result  input  DATA_W  connected to fp_adder result.
- in_flags  input  FLAG_W  connected to fp_adder flags.
- in_mode_fp  input  1  precision of the operation: 1 = single, 0 = half.
- in_ready  output  1  connected to fp_adder ready_in; high when a push will be accepted.
- out_valid  output  1  head entry available.
- out_ready  input  1  consumer accepts the head entry.
- out_result  output  DATA_W  head result.
- out_flags  output  FLAG_W  head flags.
- out_mode_fp  output  1  head precision.
- sticky_flags  output  FLAG_W  OR of the flags of all accepted results since the last clear or reset.
- sticky_clr  input  1  synchronous clear of sticky_flags.
- count  output  $clog2(DEPTH+1)  current occupancy.
- overflow_err  output  1  sticky; set when a result arrives while the queue is full.

Behaviour:
- Reset (asynchronous, rst_n low):
  - Read and write pointers = 0, count = 0.
  - out_valid = 0, in_ready = 1, sticky_flags = 0, overflow_err = 0.
  - out_result, out_flags and out_mode_fp = 0.
  - Reset asserted mid-operation discards all stored entries immediately; no partial state survives.
- Push: occurs when in_valid && in_ready at a rising clk edge.
  - Stores {in_mode_fp, in_flags, stored_result}.
  - Single mode: stored_result = in_result.
  - Half mode: stored_result = {16'b0, in_result[15:0]}; the upper half is always forced to zero regardless of input.
- Pop: occurs when out_valid && out_ready at a rising clk edge. The read pointer advances.
- in_ready = (count != DEPTH), combinational from registered count.
- out_valid = (count != 0), registered-state based.
- Output is first-word-fall-through: out_result, out_flags and out_mode_fp always reflect the head entry while out_valid = 1; they are 0 when empty.
- Latency: a push into an empty queue gives out_valid = 1 in the following cycle. There is no same-cycle bypass.
- Simultaneous push and pop:
  - Count is unchanged and both pointers advance.
  - Allowed at any count from 1 to DEPTH-1.
  - When full, in_ready = 0, so only the pop occurs (no pass-through when full).
- Pointers wrap modulo DEPTH. Order is strictly FIFO.
- Overflow:
  - If in_valid = 1 while in_ready = 0, the input is dropped and overflow_err is set to 1.
  - overflow_err stays set until reset.
  - count, stored contents and sticky_flags are unaffected by a dropped push.
- sticky_flags, next value by priority:
  - sticky_clr && push: in_flags (clear first, then accumulate the new result).
  - sticky_clr only: 0.
  - push only: sticky_flags | in_flags.
  - otherwise: hold.
- Flag bit meanings are defined by fp_adder; this block only passes them through and ORs them, and interprets none of them.
- out_ready while empty has no effect. Pointers never underflow.

Test Plan:
1. Basic single-precision push/pop:
   - Stimulus: after reset, push in_result=41B8_0000, flags=00000, mode=1; hold out_ready=0 for 3 cycles, then assert it.
   - Required: out_valid=1 from the cycle after the push; out_result=41B8_0000; count=1; after the pop, count=0 and out_valid=0.
2. Half-precision zeroing:
   - Stimulus: push in_result=ABCD_5028 with mode=0.
   - Required: out_result=0000_5028 and out_mode_fp=0.
3. Full and overflow:
   - Stimulus: push 4 results (3F80_0000, 4000_0000, 4040_0000, 4080_0000) with out_ready=0, then a 5th in_valid pulse with 7F80_0000.
   - Required: in_ready=0 after the 4th push; count=4; overflow_err=1; popping yields exactly the first 4 values in order; 7F80_0000 never appears.
4. Sticky flags:
   - Stimulus: push with flags 00001, then push with flags 10000.
   - Required: sticky_flags=10001.
   - Stimulus: next cycle, sticky_clr together with a push carrying flags 00100.
   - Required: sticky_flags=00100.
   - Stimulus: sticky_clr alone.
   - Required: sticky_flags=00000.
5. Wrap-around with concurrent traffic:
   - Stimulus: preload 2 entries, then 10 cycles of simultaneous push and pop with incrementing results 0000_0001..0000_000A.
   - Required: count stays 2 throughout; popped sequence is the 2 preloaded values followed by 0000_0001..0000_0008 in order.
6. Reset mid-operation:
   - Stimulus: with 3 entries queued and sticky_flags=00011, drop rst_n for 1 ns between clock edges.
   - Required: immediately count=0, out_valid=0, sticky_flags=0, overflow_err=0, in_ready=1; after rst_n is released, the next push behaves as in scenario 1.
